// File: rtl/division_pkg.sv
// -----------------------------------------------------------------------------
// division_pkg
// Items shared by the restoring divider and its reconstruction checker.
//   QW_DEF / DW_DEF : default quotient and divisor/remainder widths
//   state_e         : sequencer state encoding (IDLE / CALC / DONE)
// -----------------------------------------------------------------------------
package division_pkg;

    localparam int QW_DEF = 8;
    localparam int DW_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/restoring_division_check_if.sv
// -----------------------------------------------------------------------------
// restoring_division_check_if
// Request/result bundle between the checker and whoever drives it.
//   start, quotient, divisor, remainder : request side (master -> slave)
//   busy, done, product, invalid        : result side  (slave -> master)
// -----------------------------------------------------------------------------
interface restoring_division_check_if #(
    parameter int QW = 8,
    parameter int DW = 4
) ();

    logic          start;
    logic [QW-1:0] quotient;
    logic [DW-1:0] divisor;
    logic [DW-1:0] remainder;
    logic          busy;
    logic          done;
    logic [QW+DW-1:0] product;
    logic          invalid;

    modport master (
        output start, quotient, divisor, remainder,
        input  busy, done, product, invalid
    );

    modport slave (
        input  start, quotient, divisor, remainder,
        output busy, done, product, invalid
    );

endinterface

// File: rtl/restoring_division_check_datapath.sv
// -----------------------------------------------------------------------------
// rdc_datapath
// Shift-add registers for q*d + r. On load the accumulator starts at the
// remainder; each calc step adds the shifted quotient when the current
// divisor LSB is set, then shifts quotient left and divisor right.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture operands (takes priority over calc)
//   calc      : perform one shift-add step
//   quotient, divisor, remainder : operands sampled on load
//   acc_next  : accumulator value after the current step (final result on
//               the last step)
//   last      : current step is the final one (cnt == DW-1)
// -----------------------------------------------------------------------------
module rdc_datapath
    import division_pkg::*;
#(
    parameter int QW = QW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             calc,
    input  logic [QW-1:0]    quotient,
    input  logic [DW-1:0]    divisor,
    input  logic [DW-1:0]    remainder,
    output logic [QW+DW-1:0] acc_next,
    output logic             last
);

    localparam int PW = QW + DW;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    logic [PW-1:0] acc_r;
    logic [PW-1:0] q_r;
    logic [DW-1:0] d_r;
    logic [CW-1:0] cnt_r;
    logic [PW-1:0] acc_next_s;

    // Conditional add of the weighted quotient; wraps modulo 2^PW, which
    // cannot actually happen for legal widths.
    always_comb begin
        acc_next_s = acc_r;
        if (d_r[0]) begin
            acc_next_s = acc_r + q_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    assign acc_next = acc_next_s;
    assign last     = (cnt_r == CW'(DW - 1));

    // Operand capture and per-step shift of quotient/divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {PW{1'b0}};
            q_r   <= {PW{1'b0}};
            d_r   <= {DW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            acc_r <= PW'(remainder);
            q_r   <= PW'(quotient);
            d_r   <= divisor;
            cnt_r <= {CW{1'b0}};
        end else if (calc) begin
            acc_r <= acc_next_s;
            q_r   <= {q_r[PW-2:0], 1'b0};
            d_r   <= {1'b0, d_r[DW-1:1]};
            cnt_r <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/restoring_division_check.sv
// -----------------------------------------------------------------------------
// restoring_division_check
// Rebuilds the dividend from a divider result: product = q*d + r, computed
// over DW shift-add steps. Also flags operand pairs no divider can produce
// (divisor == 0 or remainder >= divisor); the product is still computed.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (wins over start)
//   bus  : slave side of restoring_division_check_if
//          start/quotient/divisor/remainder in, busy/done/product/invalid out
// All outputs are registered; product/invalid change only on the done edge.
// -----------------------------------------------------------------------------
module restoring_division_check
    import division_pkg::*;
#(
    parameter int QW = QW_DEF,
    parameter int DW = DW_DEF
) (
    input logic                     clk,
    input logic                     rst,
    restoring_division_check_if.slave bus
);

    localparam int PW = QW + DW;

    function automatic logic operands_invalid(input logic [DW-1:0] d,
                                              input logic [DW-1:0] r);
        return (d == {DW{1'b0}}) || (r >= d);
    endfunction

    state_e        state_r;
    state_e        next_s;
    logic          load_s;
    logic          calc_s;
    logic          finish_s;
    logic          busy_r;
    logic          done_r;
    logic [PW-1:0] product_r;
    logic          invalid_r;
    logic          inv_pend_r;
    logic [PW-1:0] acc_next_s;
    logic          last_s;

    rdc_datapath #(.QW(QW), .DW(DW)) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .calc      (calc_s),
        .quotient  (bus.quotient),
        .divisor   (bus.divisor),
        .remainder (bus.remainder),
        .acc_next  (acc_next_s),
        .last      (last_s)
    );

    // Next-state and datapath control. start is only looked at in IDLE/DONE,
    // so a pulse during CALC is dropped.
    always_comb begin
        next_s   = state_r;
        load_s   = 1'b0;
        calc_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    next_s = S_CALC;
                    load_s = 1'b1;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_CALC: begin
                calc_s = 1'b1;
                if (last_s) begin
                    next_s   = S_DONE;
                    finish_s = 1'b1;
                end else begin
                    next_s = S_CALC;
                end
            end
            default: begin
                next_s = S_IDLE;
            end
        endcase
    end

    // State register plus registered status/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            product_r  <= {PW{1'b0}};
            invalid_r  <= 1'b0;
            inv_pend_r <= 1'b0;
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s == S_CALC);
            done_r  <= finish_s;
            if (load_s) begin
                inv_pend_r <= operands_invalid(bus.divisor, bus.remainder);
            end
            if (finish_s) begin
                product_r <= acc_next_s;
                invalid_r <= inv_pend_r;
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
    assign bus.invalid = invalid_r;

endmodule

// File: tb/tb_restoring_division_check.sv
// -----------------------------------------------------------------------------
// tb_restoring_division_check
// Directed bench for restoring_division_check (QW=8, DW=4). Inputs are driven
// and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_restoring_division_check;

    logic clk = 1'b0;
    logic rst;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    restoring_division_check_if #(.QW(8), .DW(4)) bus ();

    restoring_division_check #(.QW(8), .DW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation starting at the current falling edge; returns at the
    // falling edge where done is expected high.
    task automatic run_op(input logic [7:0] q, input logic [3:0] d, input logic [3:0] r,
                          input logic [11:0] exp_p, input logic exp_inv,
                          input string tag, input bit scramble);
        int cyc;
        int nbusy;
        bus.start     = 1'b1;
        bus.quotient  = q;
        bus.divisor   = d;
        bus.remainder = r;
        @(negedge clk);
        bus.start = 1'b0;
        if (scramble) begin
            bus.quotient  = 8'($urandom);
            bus.divisor   = 4'($urandom);
            bus.remainder = 4'($urandom);
        end
        cyc   = 1;
        nbusy = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            if (bus.busy === 1'b1) nbusy++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, cyc, 5);
        chk({tag, " busy_cycles"}, nbusy, 4);
        chk({tag, " busy_at_done"}, bus.busy, 1'b0);
        chk({tag, " product"}, bus.product, exp_p);
        chk({tag, " invalid"}, bus.invalid, exp_inv);
    endtask

    // Falling edge after a done with start low: done drops, result holds.
    task automatic idle_chk(input string tag, input logic [11:0] exp_p);
        @(negedge clk);
        chk({tag, " done_drop"}, bus.done, 1'b0);
        chk({tag, " product_hold"}, bus.product, exp_p);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        int b;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.quotient  = 8'h00;
        bus.divisor   = 4'h0;
        bus.remainder = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset done", bus.done, 1'b0);
        chk("reset product", bus.product, 12'h000);
        chk("reset invalid", bus.invalid, 1'b0);

        // rst and start together: reset wins
        bus.start    = 1'b1;
        bus.quotient = 8'h11;
        bus.divisor  = 4'h1;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("rst_start busy", bus.busy, 1'b0);
        @(negedge clk);
        chk("rst_start busy2", bus.busy, 1'b0);
        chk("rst_start done", bus.done, 1'b0);

        run_op(8'h10, 4'h3, 4'h0, 12'h030, 1'b0, "t1", 1'b0);
        idle_chk("t1", 12'h030);

        run_op(8'h0A, 4'h6, 4'h4, 12'h040, 1'b0, "t2a", 1'b0);
        idle_chk("t2a", 12'h040);
        run_op(8'h0A, 4'h6, 4'h6, 12'h042, 1'b1, "t2b", 1'b0);
        idle_chk("t2b", 12'h042);

        run_op(8'h55, 4'h0, 4'h3, 12'h003, 1'b1, "t3a", 1'b0);
        idle_chk("t3a", 12'h003);
        run_op(8'hFF, 4'hF, 4'hE, 12'hEFF, 1'b0, "t3b", 1'b0);
        idle_chk("t3b", 12'hEFF);

        // start pulse during the 2nd CALC cycle must be ignored
        bus.start     = 1'b1;
        bus.quotient  = 8'h40;
        bus.divisor   = 4'h4;
        bus.remainder = 4'h0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.quotient = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        chk("t4 busy_mid", bus.busy, 1'b1);
        chk("t4 done_mid", bus.done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t4 done", bus.done, 1'b1);
        chk("t4 product", bus.product, 12'h100);
        chk("t4 invalid", bus.invalid, 1'b0);
        // back-to-back: start raised in the DONE cycle
        run_op(8'h02, 4'h2, 4'h0, 12'h004, 1'b0, "t4 b2b", 1'b0);
        idle_chk("t4 b2b", 12'h004);

        // reset in the 3rd CALC cycle
        bus.start     = 1'b1;
        bus.quotient  = 8'hC0;
        bus.divisor   = 4'hC;
        bus.remainder = 4'h0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5 busy", bus.busy, 1'b0);
        chk("t5 product", bus.product, 12'h000);
        chk("t5 invalid", bus.invalid, 1'b0);
        chk("t5 done", bus.done, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5 no_done", bus.done, 1'b0);
        end
        run_op(8'hC0, 4'hC, 4'h0, 12'h900, 1'b0, "t5 fresh", 1'b0);
        idle_chk("t5 fresh", 12'h900);

        // divider outputs for random a / b must reconstruct a
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 15));
            run_op(8'(a / b), 4'(b), 4'(a % b), 12'(a), 1'b0, "rand", 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/restoring_division_check.md
Name: restoring_division_check

Overview:
- Sequential shift-add reconstructor: the inverse of the team's restoring divider.
- Given quotient q, divisor d and remainder r, computes product = q*d + r, i.e. recovers the dividend.
- Also flags inputs no divider could have produced.
- Sits beside the divider in self-check paths: divider output feeds this block, and its product is compared against the original dividend.

Parameters:
QW, 8, quotient width (bits)
DW, 4, divisor and remainder width (bits); also the iteration count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only when not busy
quotient  input  QW  quotient operand
divisor  input  DW  divisor operand
remainder  input  DW  remainder operand
busy  output  1  high while computing
done  output  1  one-cycle pulse; product/invalid valid from this cycle
product  output  QW+DW  q*d + r, held until the next accepted start
invalid  output  1  set when divisor==0 or remainder>=divisor; held with product

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, internal registers 0.
- FSM states: IDLE, CALC, DONE.
- IDLE/DONE to CALC (on edge with start=1):
  - latch q_reg=quotient (zero-extended to QW+DW) and d_reg=divisor;
  - set acc=remainder (zero-extended) and cnt=0;
  - compute invalid_next = (divisor==0) or (remainder>=divisor);
  - busy=1 from the next cycle.
- CALC, each edge:
  - if d_reg[0]: acc = acc + q_reg, modulo 2^(QW+DW);
  - q_reg <<= 1; d_reg >>= 1; cnt++.
- CALC exit: on the edge where cnt==DW-1 (the DW-th CALC edge):
  - product <= final acc; invalid <= invalid_next;
  - done <= 1; busy <= 0; go to DONE.
- DONE: done is high for exactly one cycle.
  - DONE with start=0 -> IDLE; done returns to 0.
  - DONE with start=1 -> restart as from IDLE (back-to-back); done drops to 0 that cycle.
- Latency: start sampled at edge k; done=1 in the cycle after edge k+DW. Total DW+1 edges; 5 with defaults.
- Width: maximum result is (2^QW-1)(2^DW-1)+(2^DW-1) = (2^DW-1)*2^QW < 2^(QW+DW). No overflow is possible, so there is no carry-out port.
- start while busy=1 is ignored. Operands may change freely during CALC; only the latched copies are used.
- product and invalid change only on the done edge. Between operations they hold their last value.
- invalid does not abort the computation. The product is still computed; with divisor==0 it equals remainder.
- Reset asserted mid-CALC: next state IDLE, outputs zeroed, partial result discarded, no done pulse.
- rst and start in the same cycle: rst wins.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package (division_pkg):
  - state encoding constants S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2;
  - default widths QW_DEF=8, DW_DEF=4;
  - shared with the divider.
- One sub-module: rdc_datapath, holding the acc/q_reg/d_reg shift-add registers and the cnt counter.
- The FSM plus the invalid/done/busy logic stays in the top module.

Test Plan:
- q=0x10, d=0x3, r=0x0, start pulse -> busy=1 for 4 cycles, done pulse 5 cycles after start; product=0x030, invalid=0.
- q=0x0A, d=0x6, r=0x4 -> product=0x040 (64), invalid=0. Then q=0x0A, d=0x6, r=0x6 -> product=0x042, invalid=1.
- q=0x55, d=0x0, r=0x3 -> product=0x003, invalid=1. Then q=0xFF, d=0xF, r=0xE -> product=0xEFF, invalid=0.
- Start with q=0x40, d=0x4; pulse start again during the 2nd CALC cycle with q=0x01 -> ignored, product=0x100. Start held high at the DONE cycle with q=0x02, d=0x2 -> back-to-back result 0x004, 5 cycles later.
- Start q=0xC0, d=0xC; assert rst in the 3rd CALC cycle -> next cycle busy=0, product=0, invalid=0, no done pulse. A fresh start then computes 0x900 normally.
- Random loop, 1000 ops: feed the divider's {quotient, remainder} for random a (8-bit), b≠0 (4-bit) -> product==a and invalid==0 every time.
